cache_sim_lru: RTL and testbench
================================

CACHE_SIM_LRU -- requirements
Module: cache_sim_lru

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: trace address width.
REQ-002 SHALL have parameter LINE_BITS, default 4: byte-offset bits, giving 16-byte lines.
REQ-003 SHALL have parameter SET_BITS, default 4: index bits, giving 16 sets.
REQ-004 SHALL have parameter WAYS, default 4: associativity; power of two, 1..16.
REQ-005 SHALL have parameter CNT_W, default 10: width of each statistics counter.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port trace_valid, input, 1 bit: trace_addr holds a valid access.
REQ-009 SHALL have port trace_ready, output, 1 bit: the block can accept an access.
REQ-010 SHALL have port trace_addr, input, ADDR_W bits: access address.
REQ-011 SHALL have port clear_counts, input, 1 bit: synchronous zeroing of the statistics counters.
REQ-012 SHALL have ports access_count, hit_count, miss_count and evict_count, each output, CNT_W bits: statistics.
REQ-013 SHALL have port updated, output, 1 bit: one-cycle pulse when an access's result has been committed.
REQ-014 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 SHALL split the address as follows: set = trace_addr[LINE_BITS+SET_BITS-1:LINE_BITS]; tag = trace_addr[ADDR_W-1:LINE_BITS+SET_BITS].
REQ-016 SHALL keep per set and per way a valid bit, a tag, and an age of log2(WAYS) bits, where age 0 is MRU.
REQ-017 SHALL implement the FSM IDLE -> LOOKUP -> UPDATE -> IDLE; each state lasts exactly one cycle.
REQ-018 SHALL drive trace_ready = 1 only in IDLE; an access is accepted when trace_valid && trace_ready, and the address is captured into a register.
REQ-019 SHALL, in LOOKUP, compare the captured tag against all valid ways of the set and register the hit flag and hit way.
REQ-020 SHALL choose the victim on a miss as the lowest-index invalid way; if every way is valid, the victim is the way whose age == WAYS-1.
REQ-021 SHALL, in UPDATE, write the tag and valid bit into the victim on a miss; on a miss to a fully valid set it also increments evict_count.
REQ-022 SHALL apply the same LRU update in UPDATE for the target way t (hit way or victim): every way with age < age[t] increments, then age[t] = 0. For an invalid victim, age[t] is taken as WAYS-1.
REQ-023 SHALL, in UPDATE, increment access_count and exactly one of hit_count or miss_count, and assert updated for that cycle only.
REQ-024 SHALL saturate every counter at 2^CNT_W-1; a counter never wraps.
REQ-025 SHALL make clear_counts zero all four counters on the next edge in any state, and it wins over a simultaneous UPDATE increment; tags, valid bits and ages are untouched.
REQ-026 SHALL sustain a throughput of one access per 3 cycles; updated is asserted 2 cycles after the acceptance edge.
REQ-027 SHALL, for WAYS=1, make every miss to a valid line an eviction; the ages are constant 0.

Reset
REQ-028 SHALL, when reset is high at an edge, set the state to IDLE, clear all valid bits, set age[w] = w for each set, zero all counters, and set updated = 0, busy = 0, trace_ready = 1.
REQ-029 SHALL, on reset mid-access (LOOKUP or UPDATE), abandon the in-flight access with no counter or tag update; reset has priority over clear_counts and over a trace handshake.

Verification
REQ-030 SHALL cover: after reset, access 0x100 then 0x10C -> miss then hit (same line); access=2, hit=1, miss=1, evict=0; updated pulses twice.
REQ-031 SHALL cover LRU: accesses 0x000,0x100,0x200,0x300,0x400 (all set 0), then 0x000, then 0x200 -> counts access=7, hit=1, miss=6, evict=2; 0x100 is evicted by the second 0x000.
REQ-032 SHALL cover saturation: with CNT_W=4, 20 accesses to 0x40 -> access=15, hit=15, miss=1, with no wrap.
REQ-033 SHALL cover reset mid-operation: reset asserted in LOOKUP of the first access to 0x80 -> all counters 0 and trace_ready=1 on the next cycle; a re-access of 0x80 then misses.
REQ-034 SHALL cover clear_counts asserted in the UPDATE cycle of a miss to 0x20 -> all counters 0 and updated=1; the next access to 0x20 hits, leaving hit=1, access=1.
REQ-035 SHALL cover the handshake: trace_valid held high continuously -> trace_ready high in 1 of every 3 cycles, busy=1 in the other two, and no access dropped or duplicated.

Source files
------------

// File: rtl/cache_sim_lru.sv
// Set-associative cache hit/miss simulator with true-LRU replacement and
// saturating statistics; one trace access every three cycles.
module cache_sim_lru #(
   parameter int ADDR_W    = 32,
   parameter int LINE_BITS = 4,
   parameter int SET_BITS  = 4,
   parameter int WAYS      = 4,
   parameter int CNT_W     = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              trace_valid,
   output logic              trace_ready,
   input  logic [ADDR_W-1:0] trace_addr,
   input  logic              clear_counts,
   output logic [CNT_W-1:0]  access_count,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count,
   output logic [CNT_W-1:0]  evict_count,
   output logic              updated,
   output logic              busy
);

   localparam int SETS  = 1 << SET_BITS;
   localparam int TAG_W = ADDR_W - LINE_BITS - SET_BITS;
   localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int WAY_W = AGE_W;

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      UPDATE
   } state_t;

   state_t state_q, state_d;

   logic [ADDR_W-LINE_BITS-1:0] addr_q;
   logic [SET_BITS-1:0]         set_idx;
   logic [TAG_W-1:0]            tag_in;
   logic                        unused_offset;

   logic                        valid_mem [SETS][WAYS];
   logic [TAG_W-1:0]            tag_mem   [SETS][WAYS];
   logic [AGE_W-1:0]            age_mem   [SETS][WAYS];

   logic                        hit_c, inv_found;
   logic [WAY_W-1:0]            hit_way_c, inv_way, old_way, victim_c;

   logic                        hit_q, full_q;
   logic [WAY_W-1:0]            hit_way_q, victim_q;

   logic [WAY_W-1:0]            tgt;
   logic [AGE_W-1:0]            age_t;

   assign unused_offset = ^trace_addr[LINE_BITS-1:0];
   assign set_idx       = addr_q[SET_BITS-1:0];
   assign tag_in        = addr_q[ADDR_W-LINE_BITS-1:SET_BITS];

   assign trace_ready = (state_q == IDLE);
   assign busy        = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (trace_valid) state_d = LOOKUP;
         LOOKUP:  state_d = UPDATE;
         UPDATE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Tag match plus victim choice: lowest invalid way, else the oldest way.
   always_comb begin
      hit_c     = 1'b0;
      hit_way_c = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      old_way   = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (valid_mem[set_idx][WAY_W'(w)] && !hit_c &&
             tag_mem[set_idx][WAY_W'(w)] == tag_in) begin
            hit_c     = 1'b1;
            hit_way_c = WAY_W'(w);
         end
         if (!valid_mem[set_idx][WAY_W'(w)] && !inv_found) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
         if (age_mem[set_idx][WAY_W'(w)] == AGE_W'(WAYS - 1))
            old_way = WAY_W'(w);
      end
      victim_c = inv_found ? inv_way : old_way;
   end

   assign tgt   = hit_q ? hit_way_q : victim_q;
   assign age_t = hit_q ? age_mem[set_idx][tgt] : AGE_W'(WAYS - 1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         updated   <= 1'b0;
         addr_q    <= '0;
         hit_q     <= 1'b0;
         full_q    <= 1'b0;
         hit_way_q <= '0;
         victim_q  <= '0;
      end else begin
         state_q <= state_d;
         updated <= (state_q == UPDATE);
         if (state_q == IDLE && trace_valid)
            addr_q <= trace_addr[ADDR_W-1:LINE_BITS];
         if (state_q == LOOKUP) begin
            hit_q     <= hit_c;
            hit_way_q <= hit_way_c;
            victim_q  <= victim_c;
            full_q    <= !inv_found;
         end
      end
   end

   // An invalid victim is treated as oldest so the filled ways stay a recency permutation.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned s = 0; s < SETS; s++) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
               valid_mem[SET_BITS'(s)][WAY_W'(w)] <= 1'b0;
               age_mem[SET_BITS'(s)][WAY_W'(w)]   <= AGE_W'(w);
            end
         end
      end else if (state_q == UPDATE) begin
         for (int unsigned w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == tgt)
               age_mem[set_idx][WAY_W'(w)] <= '0;
            else if (age_mem[set_idx][WAY_W'(w)] < age_t)
               age_mem[set_idx][WAY_W'(w)] <= age_mem[set_idx][WAY_W'(w)] + 1'b1;
         end
         if (!hit_q) begin
            valid_mem[set_idx][tgt] <= 1'b1;
            tag_mem[set_idx][tgt]   <= tag_in;
         end
      end
   end

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset || clear_counts) begin
         access_count <= '0;
         hit_count    <= '0;
         miss_count   <= '0;
         evict_count  <= '0;
      end else if (state_q == UPDATE) begin
         access_count <= sat_inc(access_count);
         if (hit_q)
            hit_count <= sat_inc(hit_count);
         else
            miss_count <= sat_inc(miss_count);
         if (!hit_q && full_q)
            evict_count <= sat_inc(evict_count);
      end
   end

endmodule

// File: tb/tb_cache_sim_lru.sv
// Bench for cache_sim_lru: directed scenarios plus random traffic against a
// timestamp-LRU reference; a CNT_W=4 copy shares the stimulus to exercise saturation.
module tb_cache_sim_lru;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        trace_valid = 1'b0;
   logic        clear_counts = 1'b0;
   logic [31:0] trace_addr = '0;

   logic       trace_ready, updated, busy;
   logic [9:0] access_count, hit_count, miss_count, evict_count;
   logic       s_ready, s_updated, s_busy;
   logic [3:0] s_access, s_hit, s_miss, s_evict;

   int unsigned total = 0;
   int unsigned bad   = 0;

   always #5 clk = ~clk;

   cache_sim_lru #(.ADDR_W(32), .LINE_BITS(4), .SET_BITS(4), .WAYS(4), .CNT_W(10)) dut (
      .clk(clk), .reset(reset), .trace_valid(trace_valid), .trace_ready(trace_ready),
      .trace_addr(trace_addr), .clear_counts(clear_counts),
      .access_count(access_count), .hit_count(hit_count), .miss_count(miss_count),
      .evict_count(evict_count), .updated(updated), .busy(busy));

   cache_sim_lru #(.ADDR_W(32), .LINE_BITS(4), .SET_BITS(4), .WAYS(4), .CNT_W(4)) dut_sat (
      .clk(clk), .reset(reset), .trace_valid(trace_valid), .trace_ready(s_ready),
      .trace_addr(trace_addr), .clear_counts(clear_counts),
      .access_count(s_access), .hit_count(s_hit), .miss_count(s_miss),
      .evict_count(s_evict), .updated(s_updated), .busy(s_busy));

   // Reference: per-set entries stamped with last-use time; LRU = smallest stamp.
   bit          m_valid [16][4];
   int unsigned m_tag   [16][4];
   int unsigned m_time  [16][4];
   int unsigned stamp;
   int unsigned m_acc, m_hit, m_miss, m_evict;

   function automatic int unsigned sat(input int unsigned v, input int unsigned w);
      int unsigned lim;
      lim = (32'd1 << w) - 1;
      return (v > lim) ? lim : v;
   endfunction

   task automatic model_clear();
      m_acc = 0; m_hit = 0; m_miss = 0; m_evict = 0;
   endtask

   task automatic model_reset();
      for (int s = 0; s < 16; s++)
         for (int w = 0; w < 4; w++) begin
            m_valid[s][w] = 1'b0; m_tag[s][w] = 0; m_time[s][w] = 0;
         end
      stamp = 1;
      model_clear();
   endtask

   task automatic model_access(input logic [31:0] a);
      int unsigned s, t;
      int victim;
      bit found;
      s = (a >> 4) & 32'hF;
      t = a >> 8;
      found = 1'b0;
      m_acc++;
      for (int w = 0; w < 4; w++)
         if (m_valid[s][w] && m_tag[s][w] == t) begin
            found = 1'b1; m_time[s][w] = stamp;
         end
      if (found) m_hit++;
      else begin
         m_miss++;
         victim = -1;
         for (int w = 0; w < 4; w++)
            if (!m_valid[s][w] && victim < 0) victim = w;
         if (victim < 0) begin
            m_evict++;
            victim = 0;
            for (int w = 1; w < 4; w++)
               if (m_time[s][w] < m_time[s][victim]) victim = w;
         end
         m_valid[s][victim] = 1'b1; m_tag[s][victim] = t; m_time[s][victim] = stamp;
      end
      stamp++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_counts(input string tag);
      chk({tag, ".acc"},   32'(access_count), sat(m_acc, 10));
      chk({tag, ".hit"},   32'(hit_count),    sat(m_hit, 10));
      chk({tag, ".miss"},  32'(miss_count),   sat(m_miss, 10));
      chk({tag, ".evict"}, 32'(evict_count),  sat(m_evict, 10));
      chk({tag, ".s_acc"},   32'(s_access), sat(m_acc, 4));
      chk({tag, ".s_hit"},   32'(s_hit),    sat(m_hit, 4));
      chk({tag, ".s_miss"},  32'(s_miss),   sat(m_miss, 4));
      chk({tag, ".s_evict"}, 32'(s_evict),  sat(m_evict, 4));
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".ready"},   32'(trace_ready), 1);
      chk({tag, ".s_ready"}, 32'(s_ready),     1);
      chk({tag, ".busy"},    32'(busy),        0);
      chk({tag, ".s_busy"},  32'(s_busy),      0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; trace_valid = 1'b0; clear_counts = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      @(negedge clk);
   endtask

   // act: 0 plain, 1 reset during LOOKUP, 2 clear_counts during UPDATE. Starts/ends at a negedge.
   task automatic access(input logic [31:0] a, input int act);
      int n;
      trace_addr = a; trace_valid = 1'b1;
      n = 0;
      while (!trace_ready && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) chk("ready_timeout", 0, 1);
      @(posedge clk);
      #1 trace_valid = 1'b0;
      trace_addr = $urandom;
      @(negedge clk);
      chk("lookup.busy", 32'(busy), 1);
      chk("lookup.updated", 32'(updated), 0);
      if (act == 1) begin
         reset = 1'b1;
         @(posedge clk);
         #1 reset = 1'b0;
         model_reset();
         @(negedge clk);
         chk_idle("midreset");
         chk("midreset.updated", 32'(updated), 0);
         chk_counts("midreset");
         return;
      end
      @(negedge clk);
      chk("update.ready", 32'(trace_ready), 0);
      chk("update.updated", 32'(updated), 0);
      if (act == 2) clear_counts = 1'b1;
      @(posedge clk);
      #1 clear_counts = 1'b0;
      model_access(a);
      if (act == 2) model_clear();
      @(negedge clk);
      chk("done.updated", 32'(updated), 1);
      chk("done.s_updated", 32'(s_updated), 1);
      chk_idle("done");
      chk_counts("done");
   endtask

   initial begin
      logic [31:0] a;
      int gap;
      int act;

      model_reset();
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk_idle("reset");
      chk("reset.updated", 32'(updated), 0);
      chk_counts("reset");

      // Same line twice: miss then hit.
      access(32'h100, 0);
      access(32'h10C, 0);
      chk("line.acc", 32'(access_count), 2);
      chk("line.hit", 32'(hit_count), 1);
      chk("line.miss", 32'(miss_count), 1);
      chk("line.evict", 32'(evict_count), 0);

      // LRU eviction order within set 0.
      do_reset();
      access(32'h000, 0); access(32'h100, 0); access(32'h200, 0);
      access(32'h300, 0); access(32'h400, 0); access(32'h000, 0);
      access(32'h200, 0);
      chk("lru.acc", 32'(access_count), 7);
      chk("lru.hit", 32'(hit_count), 1);
      chk("lru.miss", 32'(miss_count), 6);
      chk("lru.evict", 32'(evict_count), 2);
      access(32'h100, 0);
      chk("lru.evicted_miss", 32'(miss_count), 7);

      // Saturation on the 4-bit copy.
      do_reset();
      for (int i = 0; i < 20; i++) access(32'h40, 0);
      chk("sat.s_acc", 32'(s_access), 15);
      chk("sat.s_hit", 32'(s_hit), 15);
      chk("sat.s_miss", 32'(s_miss), 1);
      chk("sat.acc", 32'(access_count), 20);

      // Reset in LOOKUP abandons the access.
      do_reset();
      access(32'h80, 1);
      access(32'h80, 0);
      chk("midreset.remiss", 32'(miss_count), 1);
      chk("midreset.hit0", 32'(hit_count), 0);

      // clear_counts in UPDATE wins, but the line is still installed.
      do_reset();
      access(32'h20, 2);
      chk("clear.acc0", 32'(access_count), 0);
      access(32'h20, 0);
      chk("clear.hit", 32'(hit_count), 1);
      chk("clear.acc", 32'(access_count), 1);
      chk("clear.miss", 32'(miss_count), 0);

      // trace_valid held high: ready one cycle in three.
      do_reset();
      trace_valid = 1'b1;
      for (int i = 0; i < 30; i++) begin
         chk("hs.ready", 32'(trace_ready), 32'(i % 3 == 0));
         chk("hs.busy", 32'(busy), 32'(i % 3 != 0));
         a = ($urandom_range(0, 5) << 8) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
         trace_addr = a;
         if (i % 3 == 0) model_access(a);
         @(negedge clk);
      end
      trace_valid = 1'b0;
      chk("hs.updated", 32'(updated), 1);
      chk_counts("hs");

      // Random traffic with gaps and occasional clears.
      do_reset();
      for (int i = 0; i < 150; i++) begin
         gap = int'($urandom_range(0, 2));
         repeat (gap) @(negedge clk);
         a = ($urandom_range(0, 5) << 8) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
         act = ($urandom_range(0, 19) == 0) ? 2 : 0;
         access(a, act);
         if ($urandom_range(0, 29) == 0) begin
            clear_counts = 1'b1;
            @(posedge clk);
            #1 clear_counts = 1'b0;
            model_clear();
            @(negedge clk);
            chk_counts("rnd.clear");
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
